// File: rtl/jtag_tap_pkg.sv
// Shared TAP definitions: state enum, instruction codes, capture-IR pattern, IR decode.
// Latency: n/a (types and constants only). TAP_IDCODE_EN decides whether 0x1 selects IDCODE.
// Backpressure: n/a.
package jtag_tap_pkg;

    localparam int IR_WIDTH_DEF = 4;

    typedef enum logic [3:0] {
        TAP_TLR,
        TAP_RTI,
        TAP_SEL_DR,
        TAP_CAP_DR,
        TAP_SHIFT_DR,
        TAP_EXIT1_DR,
        TAP_PAUSE_DR,
        TAP_EXIT2_DR,
        TAP_UPD_DR,
        TAP_SEL_IR,
        TAP_CAP_IR,
        TAP_SHIFT_IR,
        TAP_EXIT1_IR,
        TAP_PAUSE_IR,
        TAP_EXIT2_IR,
        TAP_UPD_IR
    } tap_state_e;

    localparam logic [3:0] INSTR_IDCODE  = 4'h1;
    localparam logic [3:0] INSTR_MEMORY  = 4'h4;
    localparam logic [3:0] INSTR_FIFO    = 4'h5;
    localparam logic [3:0] INSTR_CONFREG = 4'h6;
    localparam logic [3:0] INSTR_CLK_BYP = 4'h7;
    localparam logic [3:0] INSTR_OBSERV  = 4'h8;
    localparam logic [3:0] INSTR_BYPASS  = 4'hF;

    localparam logic [1:0] CAPTURE_IR_PAT = 2'b01;

    typedef enum logic [2:0] {
        DR_BYPASS,
        DR_IDCODE,
        DR_MEMORY,
        DR_FIFO,
        DR_CONFREG,
        DR_CLK_BYP,
        DR_OBSERV
    } dr_sel_e;

`ifdef TAP_IDCODE_EN
    localparam logic [3:0] INSTR_RESET    = INSTR_IDCODE;
    localparam dr_sel_e    IDCODE_DR_SEL  = DR_IDCODE;
`else
    localparam logic [3:0] INSTR_RESET    = INSTR_BYPASS;
    localparam dr_sel_e    IDCODE_DR_SEL  = DR_BYPASS;
`endif

    // Code is zero-extended so any set bit above the 4-bit encodings falls to BYPASS.
    function automatic dr_sel_e decode_ir(input logic [31:0] code);
        dr_sel_e sel;
        case (code)
            32'(INSTR_IDCODE):  sel = IDCODE_DR_SEL;
            32'(INSTR_MEMORY):  sel = DR_MEMORY;
            32'(INSTR_FIFO):    sel = DR_FIFO;
            32'(INSTR_CONFREG): sel = DR_CONFREG;
            32'(INSTR_CLK_BYP): sel = DR_CLK_BYP;
            32'(INSTR_OBSERV):  sel = DR_OBSERV;
            default:            sel = DR_BYPASS;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 16-state TAP controller driven by tms_i.
// Latency: state advances on every tck_i rising edge.
// Backpressure: none; the host owns TCK/TMS.
module jtag_tap_fsm
    import jtag_tap_pkg::*;
(
    input  logic       tck_i,
    input  logic       rst_ni,
    input  logic       tms_i,
    output tap_state_e state
);

    tap_state_e state_nxt;

    always_ff @(posedge tck_i or negedge rst_ni) begin
        if (!rst_ni) state <= TAP_TLR;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TAP_TLR:      state_nxt = tms_i ? TAP_TLR      : TAP_RTI;
            TAP_RTI:      state_nxt = tms_i ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_DR:   state_nxt = tms_i ? TAP_SEL_IR   : TAP_CAP_DR;
            TAP_CAP_DR:   state_nxt = tms_i ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_SHIFT_DR: state_nxt = tms_i ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_EXIT1_DR: state_nxt = tms_i ? TAP_UPD_DR   : TAP_PAUSE_DR;
            TAP_PAUSE_DR: state_nxt = tms_i ? TAP_EXIT2_DR : TAP_PAUSE_DR;
            TAP_EXIT2_DR: state_nxt = tms_i ? TAP_UPD_DR   : TAP_SHIFT_DR;
            TAP_UPD_DR:   state_nxt = tms_i ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_IR:   state_nxt = tms_i ? TAP_TLR      : TAP_CAP_IR;
            TAP_CAP_IR:   state_nxt = tms_i ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_SHIFT_IR: state_nxt = tms_i ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_EXIT1_IR: state_nxt = tms_i ? TAP_UPD_IR   : TAP_PAUSE_IR;
            TAP_PAUSE_IR: state_nxt = tms_i ? TAP_EXIT2_IR : TAP_PAUSE_IR;
            TAP_EXIT2_IR: state_nxt = tms_i ? TAP_UPD_IR   : TAP_SHIFT_IR;
            TAP_UPD_IR:   state_nxt = tms_i ? TAP_SEL_DR   : TAP_RTI;
            default:      state_nxt = TAP_TLR;
        endcase
    end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP: IR, BYPASS/IDCODE DRs (IDCODE only with TAP_IDCODE_EN), user-DR decode, td_o mux.
// Latency: td_o registered, one tck_i behind the selected bit; IR takes effect on leaving Update-IR.
// Backpressure: none; serial protocol clocked by the host.
module jtag_tap_ctrl
    import jtag_tap_pkg::*;
#(
    parameter logic [31:0] IDCODE_VALUE = 32'h10000db3,
    parameter int          IR_WIDTH     = IR_WIDTH_DEF
) (
    input  logic tck_i,
    input  logic rst_ni,
    input  logic tms_i,
    input  logic td_i,
    output logic td_o,
    output logic tdo_en_o,
    output logic shift_dr_o,
    output logic update_dr_o,
    output logic capture_dr_o,
    output logic memory_sel_o,
    output logic fifo_sel_o,
    output logic confreg_sel_o,
    output logic clk_byp_sel_o,
    output logic observ_sel_o,
    output logic scan_in_o,
    input  logic memory_out_i,
    input  logic fifo_out_i,
    input  logic confreg_out_i,
    input  logic clk_byp_out_i,
    input  logic observ_out_i
);

    localparam logic [IR_WIDTH-1:0] IR_RESET = IR_WIDTH'(INSTR_RESET);

    if (IR_WIDTH < 4 || IR_WIDTH > 31 || IDCODE_VALUE[0] != 1'b1) begin : g_bad_param
        $error("jtag_tap_ctrl: IR_WIDTH must be 4..31 and IDCODE_VALUE[0] must be 1");
    end

    tap_state_e          state;
    logic [IR_WIDTH-1:0] ir;
    logic [IR_WIDTH-1:0] ir_shift;
    logic                bypass_reg;
    logic                td_nxt;
    logic                ir_to_reset;
    logic                user_dr;
    dr_sel_e             dr_sel;

    jtag_tap_fsm u_fsm (
        .tck_i  (tck_i),
        .rst_ni (rst_ni),
        .tms_i  (tms_i),
        .state  (state)
    );

    // Only TLR (hold) and Select-IR lead into TLR, so the IR reloads on the same edge.
    assign ir_to_reset = tms_i && (state == TAP_TLR || state == TAP_SEL_IR);

    always_ff @(posedge tck_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ir_shift <= '0;
            ir       <= IR_RESET;
        end else begin
            if (state == TAP_CAP_IR)
                ir_shift <= IR_WIDTH'(CAPTURE_IR_PAT);
            else if (state == TAP_SHIFT_IR)
                ir_shift <= {td_i, ir_shift[IR_WIDTH-1:1]};

            if (ir_to_reset)
                ir <= IR_RESET;
            else if (state == TAP_UPD_IR)
                ir <= ir_shift;
        end
    end

    always_ff @(posedge tck_i or negedge rst_ni) begin
        if (!rst_ni)                    bypass_reg <= 1'b0;
        else if (state == TAP_CAP_DR)   bypass_reg <= 1'b0;
        else if (state == TAP_SHIFT_DR) bypass_reg <= td_i;
    end

`ifdef TAP_IDCODE_EN
    logic [31:0] idcode_reg;

    always_ff @(posedge tck_i or negedge rst_ni) begin
        if (!rst_ni)                    idcode_reg <= IDCODE_VALUE;
        else if (state == TAP_CAP_DR)   idcode_reg <= IDCODE_VALUE;
        else if (state == TAP_SHIFT_DR) idcode_reg <= {td_i, idcode_reg[31:1]};
    end
`endif

    assign dr_sel        = decode_ir(32'(ir));
    assign memory_sel_o  = (dr_sel == DR_MEMORY);
    assign fifo_sel_o    = (dr_sel == DR_FIFO);
    assign confreg_sel_o = (dr_sel == DR_CONFREG);
    assign clk_byp_sel_o = (dr_sel == DR_CLK_BYP);
    assign observ_sel_o  = (dr_sel == DR_OBSERV);
    assign user_dr       = memory_sel_o | fifo_sel_o | confreg_sel_o | clk_byp_sel_o | observ_sel_o;

    assign capture_dr_o  = user_dr && (state == TAP_CAP_DR);
    assign shift_dr_o    = user_dr && (state == TAP_SHIFT_DR);
    assign update_dr_o   = user_dr && (state == TAP_UPD_DR);
    assign tdo_en_o      = (state == TAP_SHIFT_IR) || (state == TAP_SHIFT_DR);
    assign scan_in_o     = td_i;

    always_comb begin
        td_nxt = 1'b0;
        if (state == TAP_SHIFT_IR) begin
            td_nxt = ir_shift[0];
        end else if (state == TAP_SHIFT_DR) begin
            case (dr_sel)
`ifdef TAP_IDCODE_EN
                DR_IDCODE:  td_nxt = idcode_reg[0];
`endif
                DR_MEMORY:  td_nxt = memory_out_i;
                DR_FIFO:    td_nxt = fifo_out_i;
                DR_CONFREG: td_nxt = confreg_out_i;
                DR_CLK_BYP: td_nxt = clk_byp_out_i;
                DR_OBSERV:  td_nxt = observ_out_i;
                default:    td_nxt = bypass_reg;
            endcase
        end
    end

    always_ff @(posedge tck_i or negedge rst_ni) begin
        if (!rst_ni) td_o <= 1'b0;
        else         td_o <= td_nxt;
    end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Bench for jtag_tap_ctrl: directed 1149.1 sequences plus random TMS/TDI walks,
// checked every cycle against a table-driven TAP model held in the bench.
module tb_jtag_tap_ctrl;

    localparam logic [31:0] IDV = 32'h10000db3;
`ifdef TAP_IDCODE_EN
    localparam bit          IDC_EN  = 1'b1;
    localparam bit [3:0]    IR_RST  = 4'h1;
    localparam logic [31:0] EXP_DR0 = 32'h10000db3;
`else
    localparam bit          IDC_EN  = 1'b0;
    localparam bit [3:0]    IR_RST  = 4'hF;
    localparam logic [31:0] EXP_DR0 = 32'hFFFFFFFE;
`endif

    // Model state numbering: TLR RTI SelDR CapDR ShDR Ex1DR PDR Ex2DR UpDR SelIR CapIR ShIR Ex1IR PIR Ex2IR UpIR
    localparam int S_TLR = 0, S_CAPDR = 3, S_SHDR = 4, S_UPDR = 8;
    localparam int S_CAPIR = 10, S_SHIR = 11, S_UPIR = 15;
    int nx0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nx1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

    logic tck = 1'b0;
    logic rst_ni, tms_i, td_i;
    logic [4:0] uo;
    logic td_o, tdo_en_o, shift_dr_o, update_dr_o, capture_dr_o;
    logic memory_sel_o, fifo_sel_o, confreg_sel_o, clk_byp_sel_o, observ_sel_o, scan_in_o;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int n_cap, n_sh, n_up;

    int          m_st  = 0;
    bit [3:0]    m_irsh = 4'h0;
    bit [3:0]    m_ir  = IR_RST;
    bit          m_byp = 1'b0;
    bit [31:0]   m_idc = IDV;
    bit          m_tdo = 1'b0;

    jtag_tap_ctrl dut (
        .tck_i         (tck),
        .rst_ni        (rst_ni),
        .tms_i         (tms_i),
        .td_i          (td_i),
        .td_o          (td_o),
        .tdo_en_o      (tdo_en_o),
        .shift_dr_o    (shift_dr_o),
        .update_dr_o   (update_dr_o),
        .capture_dr_o  (capture_dr_o),
        .memory_sel_o  (memory_sel_o),
        .fifo_sel_o    (fifo_sel_o),
        .confreg_sel_o (confreg_sel_o),
        .clk_byp_sel_o (clk_byp_sel_o),
        .observ_sel_o  (observ_sel_o),
        .scan_in_o     (scan_in_o),
        .memory_out_i  (uo[0]),
        .fifo_out_i    (uo[1]),
        .confreg_out_i (uo[2]),
        .clk_byp_out_i (uo[3]),
        .observ_out_i  (uo[4])
    );

    always #5 tck = ~tck;

    // -2: IDCODE, -1: BYPASS, 0..4: user DR index (memory, fifo, confreg, clk_byp, observ)
    function automatic int dr_of(input bit [3:0] code);
        if (code == 4'h1 && IDC_EN) return -2;
        if (code >= 4'h4 && code <= 4'h8) return int'(code) - 4;
        return -1;
    endfunction

    always @(posedge tck or negedge rst_ni) begin : model
        int d;
        int nxt;
        bit t;
        if (!rst_ni) begin
            m_st = S_TLR; m_irsh = 4'h0; m_ir = IR_RST; m_byp = 1'b0; m_idc = IDV; m_tdo = 1'b0;
        end else begin
            d   = dr_of(m_ir);
            nxt = tms_i ? nx1[m_st] : nx0[m_st];
            t   = 1'b0;
            if (m_st == S_SHIR) t = m_irsh[0];
            else if (m_st == S_SHDR) t = (d == -1) ? m_byp : (d == -2) ? m_idc[0] : uo[d];
            if (m_st == S_CAPIR) m_irsh = 4'b0001;
            if (m_st == S_SHIR)  m_irsh = {td_i, m_irsh[3:1]};
            if (m_st == S_CAPDR) begin m_byp = 1'b0; m_idc = IDV; end
            if (m_st == S_SHDR)  begin m_byp = td_i; m_idc = {td_i, m_idc[31:1]}; end
            if (nxt == S_TLR) m_ir = IR_RST;
            else if (m_st == S_UPIR) m_ir = m_irsh;
            m_tdo = t;
            m_st  = nxt;
        end
    end

    always @(negedge tck) begin : cmp
        int d;
        logic [10:0] e, a;
        d = dr_of(m_ir);
        e = '0;
        e[10] = m_tdo;
        e[9]  = (m_st == S_SHDR) || (m_st == S_SHIR);
        if (d >= 0) begin
            e[8]     = (m_st == S_SHDR);
            e[7]     = (m_st == S_UPDR);
            e[6]     = (m_st == S_CAPDR);
            e[1 + d] = 1'b1;
        end
        e[0] = td_i;
        a = {td_o, tdo_en_o, shift_dr_o, update_dr_o, capture_dr_o, observ_sel_o,
             clk_byp_sel_o, confreg_sel_o, fifo_sel_o, memory_sel_o, scan_in_o};
        cmp_cnt++;
        if (a !== e) begin
            err_cnt++;
            $display("FAIL cycle_outputs t=%0t: got %b expected %b (td,en,sh,up,cap,obs,clk,conf,fifo,mem,scan)",
                     $time, a, e);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input bit tms, input bit tdi);
        tms_i = tms;
        td_i  = tdi;
        @(posedge tck);
        #2;
        if (capture_dr_o) n_cap++;
        if (shift_dr_o)   n_sh++;
        if (update_dr_o)  n_up++;
    endtask

    // From RTI: load an instruction, return the td_o bits seen while shifting (LSB first), back to RTI.
    task automatic load_ir(input bit [3:0] code, output bit [3:0] cap);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 4; i++) begin
            step(i == 3, code[i]);
            cap[i] = td_o;
        end
        step(1, 0); step(0, 0);
    endtask

    // From RTI: full DR scan of n bits with random user-DR outputs; memory_out_i values logged.
    task automatic shift_dr(input int n, input bit [31:0] tdi, output bit [31:0] tdo, output bit [31:0] mlog);
        n_cap = 0; n_sh = 0; n_up = 0;
        tdo = '0; mlog = '0;
        step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < n; i++) begin
            uo = 5'($urandom);
            mlog[i] = uo[0];
            step(i == n - 1, tdi[i]);
            tdo[i] = td_o;
        end
        step(1, 0); step(0, 0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit [3:0]  cap;
        bit [31:0] w, ml;
        rst_ni = 1'b0; tms_i = 1'b0; td_i = 1'b0; uo = '0;
        @(posedge tck); #2;
        chk("reset_td_o", 32'(td_o), 32'h0);
        chk("reset_tdo_en", 32'(tdo_en_o), 32'h0);
        chk("reset_sels", 32'({memory_sel_o, fifo_sel_o, confreg_sel_o, clk_byp_sel_o, observ_sel_o}), 32'h0);
        @(posedge tck); #2;
        rst_ni = 1'b1;

        // Default DR after reset, entered with TMS 0,1,0,0
        step(0, 1); step(1, 1); step(0, 1); step(0, 1);
        chk("in_shift_dr_en", 32'(tdo_en_o), 32'h1);
        for (int i = 0; i < 32; i++) begin
            step(i == 31, 1'b1);
            w[i] = td_o;
        end
        step(1, 0); step(0, 0);
        chk("reset_dr_word", w, EXP_DR0);
        chk("reset_dr_sels", 32'({memory_sel_o, fifo_sel_o, confreg_sel_o, clk_byp_sel_o, observ_sel_o}), 32'h0);

        // BYPASS
        load_ir(4'hF, cap);
        chk("capture_ir_pattern", 32'(cap), 32'h1);
        shift_dr(4, 32'b1101, w, ml);
        chk("bypass_delay", 32'(w[3:0]), 32'hA);

        // MEMORY
        load_ir(4'h4, cap);
        chk("capture_ir_pattern2", 32'(cap), 32'h1);
        chk("memory_sel", 32'(memory_sel_o), 32'h1);
        shift_dr(8, 32'h5A, w, ml);
        chk("memory_tdo", 32'(w[7:0]), 32'(ml[7:0]));
        chk("capture_pulses", n_cap, 1);
        chk("shift_cycles", n_sh, 8);
        chk("update_pulses", n_up, 1);

        // CONFREG, park in Pause-DR, then five TMS=1
        load_ir(4'h6, cap);
        chk("confreg_sel", 32'(confreg_sel_o), 32'h1);
        step(1, 0); step(0, 0); step(0, 0); step(1, 0); step(0, 0);
        repeat (5) step(1, 0);
        chk("tlr_confreg_sel", 32'(confreg_sel_o), 32'h0);
        chk("tlr_sels", 32'({memory_sel_o, fifo_sel_o, confreg_sel_o, clk_byp_sel_o, observ_sel_o}), 32'h0);
        step(0, 0);
        shift_dr(32, 32'hFFFFFFFF, w, ml);
        chk("tlr_dr_word", w, EXP_DR0);

        // Reset in the middle of Shift-IR
        load_ir(4'h4, cap);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        step(0, 1); step(0, 0);
        rst_ni = 1'b0;
        #1;
        chk("midreset_tdo_en", 32'(tdo_en_o), 32'h0);
        chk("midreset_update", 32'(update_dr_o), 32'h0);
        chk("midreset_mem_sel", 32'(memory_sel_o), 32'h0);
        @(posedge tck); #2;
        tms_i = 1'b0;
        rst_ni = 1'b1;
        step(0, 0);
        shift_dr(32, 32'hFFFFFFFF, w, ml);
        chk("midreset_dr_word", w, EXP_DR0);
        chk("midreset_no_update", n_up, 0);

        // Random walk with occasional reset pulses
        for (int i = 0; i < 1500; i++) begin
            uo = 5'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                rst_ni = 1'b0;
                #1;
                rst_ni = 1'b1;
            end
            step(1'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
